// File: rtl/bin12_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin12_to_bcd_pkg
// Shared constants and types for the 12-bit binary to 4-digit BCD converter.
//   WIDTH_C    : binary input width (only 12 is supported)
//   DIGITS_C   : number of BCD output digits (only 4 is supported)
//   CNT_W      : width of the shift counter
//   state_e    : converter FSM states
//   bcd_digit_t: one packed BCD digit
// -----------------------------------------------------------------------------
package bin12_to_bcd_pkg;

  localparam int WIDTH_C  = 12;
  localparam int DIGITS_C = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin12_to_bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// that the following left shift carries correctly into the next digit.
//   digit_i : BCD digit before correction
//   digit_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bin12_to_bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin12_to_bcd.sv
// -----------------------------------------------------------------------------
// bin12_to_bcd
// Sequential double-dabble converter from a 12-bit binary (signed or unsigned)
// value to four BCD digits plus a sign flag. One bit is shifted per clock; a
// result is presented 12 edges after capture and held until consumed.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_data   : binary value to convert
//   in_signed : 1 = in_data is two's complement
//   in_valid  : in_data/in_signed valid this cycle
//   in_ready  : converter idle, can accept a value
//   out_bcd   : thousands [15:12] .. units [3:0]
//   out_neg   : converted value was negative
//   out_valid : out_bcd/out_neg hold a completed result
//   out_ready : consumer accepts the result
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for in_valid, in_ready=1
// ST_SHIFT | one add-3/shift step per cycle, 12 steps total
// ST_DONE  | result held, out_valid=1, waits for out_ready
// -----------------------------------------------------------------------------
module bin12_to_bcd
  import bin12_to_bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_C,
  parameter int DIGITS = DIGITS_C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mag_q,   mag_d;
  logic [4*DIGITS-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  neg_q,   neg_d;
  logic [4*DIGITS-1:0]   bcd_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          // 0x800 signed negates to itself, which is the correct magnitude 2048
          if (in_signed && in_data[WIDTH-1]) begin
            mag_d = (~in_data) + {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            mag_d = in_data;
          end
          neg_d = in_signed & in_data[WIDTH-1];
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_bcd   = bcd_q;
  assign out_neg   = neg_q;

endmodule
